score_session_ctrl: RTL and testbench
=====================================

SCORE_SESSION_CTRL -- requirements
Module: score_session_ctrl

Interface
REQ-001 Parameter COUNTDOWN_TICKS, default 180, game_tick periods spent in READY before play (legal range 1..255).
REQ-002 Parameter OVER_HOLD_TICKS, default 120, game_tick periods spent in OVER before IDLE (legal range 1..255).
REQ-003 clk  in  1  single system clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start_req  in  1  single-cycle player start pulse.
REQ-006 hit  in  1  single-cycle collision pulse; ends play.
REQ-007 abort  in  1  single-cycle forced return to IDLE.
REQ-008 game_tick  in  1  60 Hz end-of-frame pulse, one cycle wide.
REQ-009 score  in  16  packed 4-digit BCD score from the score counter.
REQ-010 score_clr  out  1  pulse: clear the score counter.
REQ-011 game_start  out  1  pulse: start the score counter.
REQ-012 game_over  out  1  pulse: stop the score counter.
REQ-013 state  out  2  IDLE=00, READY=01, PLAY=10, OVER=11.
REQ-014 countdown  out  8  ticks remaining in READY/OVER; 0 otherwise.
REQ-015 high_score  out  16  best BCD score since reset.
REQ-016 new_high  out  1  level: last completed game set a new high score.

Function
REQ-017 All outputs SHALL be registered; no combinational input-to-output path.
REQ-018 IDLE: start_req SHALL move to READY and load countdown=COUNTDOWN_TICKS; hit, abort, game_tick ignored.
REQ-019 score_clr SHALL be high exactly for the first cycle in READY.
REQ-020 new_high SHALL clear on the same edge that enters READY.
REQ-021 READY: each game_tick SHALL decrement countdown; the tick that sees countdown==1 SHALL move to PLAY with countdown=0.
REQ-022 game_start SHALL be high exactly for the first cycle in PLAY.
REQ-023 READY/PLAY/OVER: start_req SHALL be ignored.
REQ-024 READY: hit ignored; abort SHALL move to IDLE with no game_over pulse.
REQ-025 PLAY: hit SHALL move to OVER, load countdown=OVER_HOLD_TICKS; game_over high exactly for the first cycle in OVER.
REQ-026 PLAY: abort SHALL move to IDLE with game_over high for the first IDLE cycle; high_score not updated.
REQ-027 PLAY: hit and abort in the same cycle SHALL be treated as abort.
REQ-028 PLAY: hit and game_tick in the same cycle SHALL be treated as hit; tick has no further effect.
REQ-029 OVER: score SHALL be sampled on the edge ending the third cycle in OVER (counter settled); if score > high_score (unsigned 16-bit compare, valid for BCD), high_score<=score and new_high<=1 on that edge.
REQ-030 OVER: each game_tick SHALL decrement countdown; the tick that sees countdown==1 SHALL move to IDLE; a tick before the sample edge still counts; the IDLE transition SHALL NOT occur before the sample edge (tick deferred to that edge).
REQ-031 OVER: abort SHALL move to IDLE immediately; if before the sample edge, no high_score update.
REQ-032 score values 16'h0000..16'h9999 only; equal score SHALL NOT set new_high.
REQ-033 Outputs score_clr, game_start, game_over SHALL never be high in the same cycle.

Reset
REQ-034 rst high at a rising edge SHALL force state=IDLE, countdown=0, high_score=0, new_high=0, all pulses 0, in any state, overriding every other input.
REQ-035 The first cycle after rst deasserts SHALL accept start_req normally.

Verification (COUNTDOWN_TICKS=3, OVER_HOLD_TICKS=2)
REQ-036 start_req in IDLE, then 3 game_ticks -> score_clr 1 cycle, countdown 3,2,1, state PLAY after 3rd tick, game_start 1 cycle.
REQ-037 PLAY, hit with score=16'h0042, high_score=0 -> game_over 1 cycle, third OVER cycle high_score=16'h0042, new_high=1; after 2 ticks state IDLE.
REQ-038 Second game ends with score=16'h0042 -> high_score stays 16'h0042, new_high=0 (cleared at READY entry, not set).
REQ-039 PLAY, hit+abort same cycle -> IDLE, game_over 1 cycle, high_score unchanged.
REQ-040 READY with countdown=2, hit then start_req -> both ignored; abort -> IDLE, no game_over.
REQ-041 rst mid-OVER with high_score=16'h0042 -> next cycle state=00, high_score=0, new_high=0, countdown=0.

Source files
------------

// File: rtl/score_session_ctrl.sv
// rtl/score_session_ctrl.sv - game session sequencer: countdown, play, game-over hold, high score.
module score_session_ctrl #(
  parameter int unsigned COUNTDOWN_TICKS = 180,
  parameter int unsigned OVER_HOLD_TICKS = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_req,
  input  logic        hit,
  input  logic        abort,
  input  logic        game_tick,
  input  logic [15:0] score,
  output logic        score_clr,
  output logic        game_start,
  output logic        game_over,
  output logic [1:0]  state,
  output logic [7:0]  countdown,
  output logic [15:0] high_score,
  output logic        new_high
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_READY = 2'b01,
    S_PLAY  = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  localparam logic [7:0] CD_LOAD = 8'(COUNTDOWN_TICKS);
  localparam logic [7:0] OH_LOAD = 8'(OVER_HOLD_TICKS);

  state_t     st;
  logic [1:0] over_age;   // completed cycles in OVER, saturating at 3
  logic       exit_pend;  // hold expired before the score was sampled
  logic       sample_edge;

  assign state       = st;
  assign sample_edge = (st == S_OVER) && (over_age == 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= S_IDLE;
      countdown  <= 8'd0;
      high_score <= 16'h0000;
      new_high   <= 1'b0;
      score_clr  <= 1'b0;
      game_start <= 1'b0;
      game_over  <= 1'b0;
      over_age   <= 2'd0;
      exit_pend  <= 1'b0;
    end else begin
      score_clr  <= 1'b0;
      game_start <= 1'b0;
      game_over  <= 1'b0;
      case (st)
        S_IDLE: begin
          if (start_req) begin
            st        <= S_READY;
            countdown <= CD_LOAD;
            score_clr <= 1'b1;
            new_high  <= 1'b0;
          end
        end
        S_READY: begin
          if (abort) begin
            st        <= S_IDLE;
            countdown <= 8'd0;
          end else if (game_tick) begin
            if (countdown == 8'd1) begin
              st         <= S_PLAY;
              countdown  <= 8'd0;
              game_start <= 1'b1;
            end else begin
              countdown <= countdown - 8'd1;
            end
          end
        end
        S_PLAY: begin
          if (abort) begin
            st        <= S_IDLE;
            game_over <= 1'b1;
          end else if (hit) begin
            st        <= S_OVER;
            countdown <= OH_LOAD;
            game_over <= 1'b1;
            over_age  <= 2'd0;
            exit_pend <= 1'b0;
          end
        end
        S_OVER: begin
          if (over_age != 2'd3) over_age <= over_age + 2'd1;
          // Score counter has settled by the end of the third OVER cycle
          if (sample_edge && (score > high_score)) begin
            high_score <= score;
            new_high   <= 1'b1;
          end
          if (abort) begin
            st        <= S_IDLE;
            countdown <= 8'd0;
          end else if (exit_pend && sample_edge) begin
            st <= S_IDLE;
          end else if (game_tick && (countdown != 8'd0)) begin
            if (countdown == 8'd1) begin
              countdown <= 8'd0;
              if (over_age >= 2'd2) st <= S_IDLE;
              else exit_pend <= 1'b1;
            end else begin
              countdown <= countdown - 8'd1;
            end
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_session_ctrl.sv
// tb/tb_score_session_ctrl.sv - directed and randomized checks of score_session_ctrl against a session model.
module tb_score_session_ctrl;

  localparam int CT = 3;
  localparam int OH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_req = 1'b0, hit = 1'b0, abort = 1'b0, game_tick = 1'b0;
  logic [15:0] score = 16'h0000;
  logic        score_clr, game_start, game_over, new_high;
  logic [1:0]  state;
  logic [7:0]  countdown;
  logic [15:0] high_score;

  int checks = 0;
  int errors = 0;

  // Session model: phase 0 idle, 1 ready, 2 play, 3 over
  int          m_phase, m_cd, m_age;
  bit          m_defer;
  logic [15:0] m_hs;
  bit          m_nh, m_clr, m_gs, m_go;

  score_session_ctrl #(.COUNTDOWN_TICKS(CT), .OVER_HOLD_TICKS(OH)) dut (
    .clk(clk), .rst(rst), .start_req(start_req), .hit(hit), .abort(abort),
    .game_tick(game_tick), .score(score), .score_clr(score_clr),
    .game_start(game_start), .game_over(game_over), .state(state),
    .countdown(countdown), .high_score(high_score), .new_high(new_high)
  );

  always #5 clk = ~clk;

  task automatic model_step(input bit r, s, h, a, t, input logic [15:0] sc);
    m_clr = 0; m_gs = 0; m_go = 0;
    if (r) begin
      m_phase = 0; m_cd = 0; m_hs = 0; m_nh = 0; m_age = 0; m_defer = 0;
      return;
    end
    case (m_phase)
      0: if (s) begin m_phase = 1; m_cd = CT; m_clr = 1; m_nh = 0; end
      1: if (a) begin m_phase = 0; m_cd = 0; end
         else if (t) begin
           m_cd = m_cd - 1;
           if (m_cd == 0) begin m_phase = 2; m_gs = 1; end
         end
      2: if (a) begin m_phase = 0; m_go = 1; end
         else if (h) begin m_phase = 3; m_cd = OH; m_go = 1; m_age = 0; m_defer = 0; end
      default: begin
        m_age = m_age + 1;
        if (m_age == 3 && sc > m_hs) begin m_hs = sc; m_nh = 1; end
        if (a) begin m_phase = 0; m_cd = 0; end
        else begin
          if (t && m_cd > 0) begin
            m_cd = m_cd - 1;
            if (m_cd == 0) m_defer = 1;
          end
          if (m_defer && m_age >= 3) m_phase = 0;
        end
      end
    endcase
  endtask

  task automatic drive(input bit r, s, h, a, t, input logic [15:0] sc);
    rst = r; start_req = s; hit = h; abort = a; game_tick = t; score = sc;
    @(posedge clk);
    #1;
    rst = 0; start_req = 0; hit = 0; abort = 0; game_tick = 0;
    model_step(r, s, h, a, t, sc);
  endtask

  task automatic idle_cyc(input logic [15:0] sc);
    drive(0, 0, 0, 0, 0, sc);
  endtask

  task automatic to_play();
    drive(0, 1, 0, 0, 0, 16'h0);
    for (int i = 0; i < CT; i++) begin
      drive(0, 0, 0, 0, 1, 16'h0);
      idle_cyc(16'h0);
    end
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 1, 1, 16'h1234);
    if ({state, countdown} !== 10'd0) begin errors++; $display("FAIL reset_state: got %h/%0d want 0/0", state, countdown); end
    checks++;
    if ({high_score, new_high, score_clr, game_start, game_over} !== 20'd0) begin
      errors++; $display("FAIL reset_regs: hs=%h nh=%b pulses=%b%b%b want zeros", high_score, new_high, score_clr, game_start, game_over);
    end
    checks++;
  endtask

  task automatic test_basic_game();
    drive(0, 1, 0, 0, 0, 16'h0);
    if ({state, countdown, score_clr} !== {2'b01, 8'd3, 1'b1}) begin errors++; $display("FAIL ready_entry: st=%b cd=%0d clr=%b want 01/3/1", state, countdown, score_clr); end
    checks++;
    idle_cyc(16'h0);
    if (score_clr !== 1'b0) begin errors++; $display("FAIL clr_width: clr=%b want 0", score_clr); end
    checks++;
    for (int k = 2; k >= 1; k--) begin
      drive(0, 0, 0, 0, 1, 16'h0);
      if (countdown !== 8'(k)) begin errors++; $display("FAIL ready_count: cd=%0d want %0d", countdown, k); end
      checks++;
      idle_cyc(16'h0);
    end
    drive(0, 0, 0, 0, 1, 16'h0);
    if ({state, countdown, game_start} !== {2'b10, 8'd0, 1'b1}) begin errors++; $display("FAIL play_entry: st=%b cd=%0d gs=%b want 10/0/1", state, countdown, game_start); end
    checks++;
    idle_cyc(16'h0);
    if (game_start !== 1'b0) begin errors++; $display("FAIL gs_width: gs=%b want 0", game_start); end
    checks++;
    drive(0, 0, 1, 0, 0, 16'h0042);
    if ({state, countdown, game_over} !== {2'b11, 8'd2, 1'b1}) begin errors++; $display("FAIL over_entry: st=%b cd=%0d go=%b want 11/2/1", state, countdown, game_over); end
    checks++;
    idle_cyc(16'h0042);
    idle_cyc(16'h0042);
    if ({high_score, game_over} !== {16'h0000, 1'b0}) begin errors++; $display("FAIL early_sample: hs=%h go=%b want 0000/0", high_score, game_over); end
    checks++;
    idle_cyc(16'h0042);
    if ({high_score, new_high} !== {16'h0042, 1'b1}) begin errors++; $display("FAIL hs_update: hs=%h nh=%b want 0042/1", high_score, new_high); end
    checks++;
    drive(0, 0, 0, 0, 1, 16'h0042);
    if ({state, countdown} !== {2'b11, 8'd1}) begin errors++; $display("FAIL over_count: st=%b cd=%0d want 11/1", state, countdown); end
    checks++;
    drive(0, 0, 0, 0, 1, 16'h0042);
    if ({state, countdown, new_high} !== {2'b00, 8'd0, 1'b1}) begin errors++; $display("FAIL over_exit: st=%b cd=%0d nh=%b want 00/0/1", state, countdown, new_high); end
    checks++;
  endtask

  task automatic test_equal_score();
    drive(0, 1, 0, 0, 0, 16'h0);
    if (new_high !== 1'b0) begin errors++; $display("FAIL nh_clear: nh=%b want 0", new_high); end
    checks++;
    for (int i = 0; i < CT; i++) drive(0, 0, 0, 0, 1, 16'h0);
    drive(0, 0, 1, 0, 0, 16'h0042);
    for (int i = 0; i < 3; i++) idle_cyc(16'h0042);
    if ({high_score, new_high} !== {16'h0042, 1'b0}) begin errors++; $display("FAIL equal_score: hs=%h nh=%b want 0042/0", high_score, new_high); end
    checks++;
    drive(0, 0, 0, 0, 1, 16'h0);
    drive(0, 0, 0, 0, 1, 16'h0);
  endtask

  task automatic test_hit_abort();
    to_play();
    drive(0, 0, 1, 1, 0, 16'h0077);
    if ({state, countdown, game_over} !== {2'b00, 8'd0, 1'b1}) begin errors++; $display("FAIL hit_abort: st=%b cd=%0d go=%b want 00/0/1", state, countdown, game_over); end
    checks++;
    for (int i = 0; i < 3; i++) idle_cyc(16'h0077);
    if ({high_score, game_over} !== {16'h0042, 1'b0}) begin errors++; $display("FAIL abort_hs: hs=%h go=%b want 0042/0", high_score, game_over); end
    checks++;
  endtask

  task automatic test_ready_ignore();
    drive(0, 1, 0, 0, 0, 16'h0);
    drive(0, 0, 0, 0, 1, 16'h0);
    drive(0, 0, 1, 0, 0, 16'h0);
    drive(0, 1, 0, 0, 0, 16'h0);
    if ({state, countdown, score_clr, game_over} !== {2'b01, 8'd2, 2'b00}) begin
      errors++; $display("FAIL ready_ignore: st=%b cd=%0d clr=%b go=%b want 01/2/0/0", state, countdown, score_clr, game_over);
    end
    checks++;
    drive(0, 0, 0, 1, 0, 16'h0);
    if ({state, countdown, game_over} !== {2'b00, 8'd0, 1'b0}) begin errors++; $display("FAIL ready_abort: st=%b cd=%0d go=%b want 00/0/0", state, countdown, game_over); end
    checks++;
  endtask

  task automatic test_reset_mid_over();
    to_play();
    drive(0, 0, 1, 0, 0, 16'h0050);
    idle_cyc(16'h0050);
    drive(1, 0, 0, 0, 0, 16'h0050);
    if ({state, countdown, high_score, new_high} !== {2'b00, 8'd0, 16'h0000, 1'b0}) begin
      errors++; $display("FAIL rst_mid_over: st=%b cd=%0d hs=%h nh=%b want 00/0/0000/0", state, countdown, high_score, new_high);
    end
    checks++;
    drive(0, 1, 0, 0, 0, 16'h0);
    if (state !== 2'b01) begin errors++; $display("FAIL post_rst_start: st=%b want 01", state); end
    checks++;
  endtask

  task automatic test_deferred_exit();
    for (int i = 0; i < CT; i++) drive(0, 0, 0, 0, 1, 16'h0);
    drive(0, 0, 1, 0, 0, 16'h0100);
    drive(0, 0, 0, 0, 1, 16'h0100);
    drive(0, 0, 0, 0, 1, 16'h0100);
    if ({state, countdown} !== {2'b11, 8'd0}) begin errors++; $display("FAIL defer_hold: st=%b cd=%0d want 11/0", state, countdown); end
    checks++;
    idle_cyc(16'h0100);
    if ({state, high_score, new_high} !== {2'b00, 16'h0100, 1'b1}) begin
      errors++; $display("FAIL defer_exit: st=%b hs=%h nh=%b want 00/0100/1", state, high_score, new_high);
    end
    checks++;
  endtask

  task automatic test_random();
    logic [15:0] sc;
    sc = 16'h0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0)
        sc = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0, sc);
      if ({state, countdown, high_score, new_high, score_clr, game_start, game_over} !==
          {2'(m_phase), 8'(m_cd), m_hs, m_nh, m_clr, m_gs, m_go}) begin
        errors++;
        $display("FAIL random_cycle %0d: st=%b cd=%0d hs=%h nh=%b p=%b%b%b want st=%0d cd=%0d hs=%h nh=%b p=%b%b%b",
                 n, state, countdown, high_score, new_high, score_clr, game_start, game_over,
                 m_phase, m_cd, m_hs, m_nh, m_clr, m_gs, m_go);
      end
      checks++;
      if (32'(score_clr) + 32'(game_start) + 32'(game_over) > 1) begin
        errors++; $display("FAIL pulse_exclusive: p=%b%b%b want at most one", score_clr, game_start, game_over);
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_game();
    test_equal_score();
    test_hit_abort();
    test_ready_ignore();
    test_reset_mid_over();
    test_deferred_exit();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
